// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared types and geometry helpers for the data cache controller
package dcache_ctrl_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int INDEX_BITS_DEF = 6;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2,
    ST_WR_DONE = 2'd3
  } state_t;

  // One word per line, so the two byte-offset bits sit below the index.
  function automatic int tag_width(input int addr_w, input int index_bits);
    return addr_w - index_bits - 2;
  endfunction

  function automatic int num_lines(input int index_bits);
    return 1 << index_bits;
  endfunction

endpackage

// File: rtl/dcache_ctrl_array.sv
// rtl/dcache_ctrl_array.sv - valid/tag/data storage: async-cleared valid bits, comb read, one sync write
module dcache_ctrl_array
  import dcache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_W      = 24,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int LINES = num_lines(INDEX_BITS);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] data [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until their valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  rd_miss_cnt,
  output logic [CNT_W-1:0]  rd_hit_cnt
);

  localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS);

  state_t state;
  logic   refill_done;

  logic [INDEX_BITS-1:0] cpu_index;
  logic [TAG_W-1:0]      cpu_tag;
  logic [ADDR_W-1:0]     word_addr;
  logic                  unused_byte_bits;

  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [DATA_W-1:0]     line_data;
  logic                  lookup_hit;

  logic                  arr_we;
  logic [DATA_W-1:0]     arr_wdata;

  assign cpu_index        = cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag          = cpu_addr[ADDR_W-1:INDEX_BITS+2];
  assign word_addr        = {cpu_addr[ADDR_W-1:2], 2'b00};
  assign unused_byte_bits = ^cpu_addr[1:0];

  dcache_ctrl_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .DATA_W     (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (cpu_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (arr_we),
    .wr_index (mem_addr[INDEX_BITS+1:2]),
    .wr_tag   (mem_addr[ADDR_W-1:INDEX_BITS+2]),
    .wr_data  (arr_wdata)
  );

  assign lookup_hit = line_valid && (line_tag == cpu_tag);

  // The pipeline holds cpu_addr stable while stalled, so the lookup during WR_THRU is the store's own line.
  always_comb begin
    arr_we    = 1'b0;
    arr_wdata = mem_wdata;
    if (state == ST_RD_MISS && mem_ready) begin
      arr_we    = 1'b1;
      arr_wdata = mem_rdata;
    end else if (state == ST_WR_THRU && mem_ready && lookup_hit) begin
      arr_we    = 1'b1;
    end
  end

  always_comb begin
    hit = 1'b1;
    case (state)
      ST_IDLE: begin
        if (cpu_write) begin
          hit = 1'b0;
        end else if (cpu_read) begin
          hit = lookup_hit;
        end
      end
      ST_RD_MISS: hit = 1'b0;
      ST_WR_THRU: hit = 1'b0;
      ST_WR_DONE: hit = 1'b1;
      default:    hit = 1'b1;
    endcase
  end

  always_comb begin
    cpu_rdata = '0;
    if (cpu_read && !cpu_write && hit) begin
      cpu_rdata = line_data;
    end
  end

  // The replayed lookup right after a refill belongs to a load already counted as a miss, so it is not counted again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      refill_done <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rd_miss_cnt <= '0;
      rd_hit_cnt  <= '0;
    end else begin
      refill_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_write) begin
            state     <= ST_WR_THRU;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= word_addr;
            mem_wdata <= cpu_wdata;
          end else if (cpu_read) begin
            if (lookup_hit) begin
              if (!refill_done && rd_hit_cnt != {CNT_W{1'b1}}) begin
                rd_hit_cnt <= rd_hit_cnt + CNT_W'(1);
              end
            end else begin
              state    <= ST_RD_MISS;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= word_addr;
              if (rd_miss_cnt != {CNT_W{1'b1}}) begin
                rd_miss_cnt <= rd_miss_cnt + CNT_W'(1);
              end
            end
          end
        end
        ST_RD_MISS: begin
          if (mem_ready) begin
            state       <= ST_IDLE;
            mem_req     <= 1'b0;
            refill_done <= 1'b1;
          end
        end
        ST_WR_THRU: begin
          if (mem_ready) begin
            state   <= ST_WR_DONE;
            mem_req <= 1'b0;
          end
        end
        ST_WR_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [15:0] rd_miss_cnt;
  logic [15:0] rd_hit_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .hit         (hit),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .rd_miss_cnt (rd_miss_cnt),
    .rd_hit_cnt  (rd_hit_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;

    #12;
    chk("rst_hit",       {31'd0, hit},       32'd1);
    chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
    chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
    chk("rst_mem_addr",  mem_addr,           32'h0);
    chk("rst_mem_wdata", mem_wdata,          32'h0);
    chk("rst_miss_cnt",  {16'd0, rd_miss_cnt}, 32'd0);
    chk("rst_hit_cnt",   {16'd0, rd_hit_cnt},  32'd0);
    chk("rst_rdata",     cpu_rdata,          32'h0);
    rst_n = 1'b1;
    step();

    // Read miss to 0x40, memory ready on the third request cycle.
    cpu_read = 1'b1; cpu_addr = 32'h0000_0040;
    look(); chk("t1_c0_hit", {31'd0, hit}, 32'd0); chk("t1_c0_req", {31'd0, mem_req}, 32'd0);
    step();
    look(); chk("t1_c1_hit", {31'd0, hit}, 32'd0); chk("t1_c1_req", {31'd0, mem_req}, 32'd1);
    chk("t1_we", {31'd0, mem_we}, 32'd0); chk("t1_addr", mem_addr, 32'h0000_0040);
    chk("t1_miss_cnt", {16'd0, rd_miss_cnt}, 32'd1);
    step();
    look(); chk("t1_c2_hit", {31'd0, hit}, 32'd0); chk("t1_c2_req", {31'd0, mem_req}, 32'd1);
    step();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    look(); chk("t1_c3_hit", {31'd0, hit}, 32'd0); chk("t1_c3_req", {31'd0, mem_req}, 32'd1);
    chk("t1_c3_rdata", cpu_rdata, 32'h0);
    step();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    look(); chk("t1_replay_hit", {31'd0, hit}, 32'd1); chk("t1_replay_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_replay_req", {31'd0, mem_req}, 32'd0);
    step();

    // Repeat read of 0x40 hits in the same cycle.
    look(); chk("t2_hit", {31'd0, hit}, 32'd1); chk("t2_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t2_req", {31'd0, mem_req}, 32'd0); chk("t2_hit_cnt_before", {16'd0, rd_hit_cnt}, 32'd0);
    step();
    cpu_read = 1'b0;
    look(); chk("t2_hit_cnt", {16'd0, rd_hit_cnt}, 32'd1); chk("t2_idle_hit", {31'd0, hit}, 32'd1);
    chk("t2_idle_rdata", cpu_rdata, 32'h0); chk("t2_miss_cnt", {16'd0, rd_miss_cnt}, 32'd1);
    step();

    // Store hit to 0x40, memory ready on the second request cycle.
    cpu_write = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = 32'h1234_5678;
    look(); chk("t3_c0_hit", {31'd0, hit}, 32'd0);
    step();
    look(); chk("t3_c1_hit", {31'd0, hit}, 32'd0); chk("t3_req", {31'd0, mem_req}, 32'd1);
    chk("t3_we", {31'd0, mem_we}, 32'd1); chk("t3_wdata", mem_wdata, 32'h1234_5678);
    chk("t3_addr", mem_addr, 32'h0000_0040);
    step();
    mem_ready = 1'b1;
    look(); chk("t3_c2_hit", {31'd0, hit}, 32'd0);
    step();
    mem_ready = 1'b0;
    look(); chk("t3_done_hit", {31'd0, hit}, 32'd1); chk("t3_done_req", {31'd0, mem_req}, 32'd0);
    step();
    cpu_write = 1'b0; cpu_read = 1'b1;
    look(); chk("t3_rd_hit", {31'd0, hit}, 32'd1); chk("t3_rd_data", cpu_rdata, 32'h1234_5678);
    step();
    cpu_read = 1'b0;
    look(); chk("t3_hit_cnt", {16'd0, rd_hit_cnt}, 32'd2);
    step();

    // Store miss to same index, different tag: memory only, minimum latency.
    cpu_write = 1'b1; cpu_addr = 32'h1000_0040; cpu_wdata = 32'hAAAA_5555;
    look(); chk("t4_c0_hit", {31'd0, hit}, 32'd0);
    step();
    mem_ready = 1'b1;
    look(); chk("t4_req", {31'd0, mem_req}, 32'd1); chk("t4_addr", mem_addr, 32'h1000_0040);
    chk("t4_wdata", mem_wdata, 32'hAAAA_5555); chk("t4_we", {31'd0, mem_we}, 32'd1);
    step();
    mem_ready = 1'b0;
    look(); chk("t4_done_hit", {31'd0, hit}, 32'd1);
    step();
    cpu_write = 1'b0; cpu_read = 1'b1; cpu_addr = 32'h0000_0040;
    look(); chk("t4_rd_hit", {31'd0, hit}, 32'd1); chk("t4_rd_data", cpu_rdata, 32'h1234_5678);
    step();

    // Conflicting read refills the line, evicting 0x40.
    cpu_addr = 32'h1000_0040;
    look(); chk("t5_c0_hit", {31'd0, hit}, 32'd0);
    step();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    look(); chk("t5_req", {31'd0, mem_req}, 32'd1); chk("t5_we", {31'd0, mem_we}, 32'd0);
    chk("t5_addr", mem_addr, 32'h1000_0040); chk("t5_miss_cnt", {16'd0, rd_miss_cnt}, 32'd2);
    step();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    look(); chk("t5_replay_hit", {31'd0, hit}, 32'd1); chk("t5_replay_data", cpu_rdata, 32'hCAFE_F00D);
    step();
    cpu_addr = 32'h0000_0040;
    look(); chk("t5_evicted_hit", {31'd0, hit}, 32'd0);
    step();
    look(); chk("t5_evict_req", {31'd0, mem_req}, 32'd1); chk("t5_evict_miss_cnt", {16'd0, rd_miss_cnt}, 32'd3);

    // Reset mid-miss abandons the refill and clears valid bits.
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", {31'd0, mem_req}, 32'd0); chk("t6_rst_miss_cnt", {16'd0, rd_miss_cnt}, 32'd0);
    chk("t6_rst_hit_cnt", {16'd0, rd_hit_cnt}, 32'd0); chk("t6_rst_hit", {31'd0, hit}, 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    look(); chk("t6_miss_req", {31'd0, mem_req}, 32'd1); chk("t6_miss_addr", mem_addr, 32'h0000_0040);
    chk("t6_miss_cnt", {16'd0, rd_miss_cnt}, 32'd1);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    look();
    step();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    look(); chk("t6_replay_data", cpu_rdata, 32'h1111_2222);
    step();

    // Simultaneous read and write is a store.
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h0000_0080; cpu_wdata = 32'h3333_4444;
    look(); chk("t6_both_hit", {31'd0, hit}, 32'd0); chk("t6_both_rdata", cpu_rdata, 32'h0);
    step();
    mem_ready = 1'b1;
    look(); chk("t6_both_we", {31'd0, mem_we}, 32'd1); chk("t6_both_wdata", mem_wdata, 32'h3333_4444);
    chk("t6_both_addr", mem_addr, 32'h0000_0080);
    step();
    mem_ready = 1'b0;
    look(); chk("t6_both_done", {31'd0, hit}, 32'd1);
    step();
    cpu_read = 1'b0; cpu_write = 1'b0;
    look(); chk("t6_final_miss_cnt", {16'd0, rd_miss_cnt}, 32'd1); chk("t6_final_req", {31'd0, mem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
